spw_tx_scheduler: RTL



---
 rtl/spw_tx_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/spw_tx_scheduler.sv
// spw_tx_scheduler: arbitrates the SpaceWire TX encoder slot and tracks both credit counters
module spw_tx_scheduler #(
  parameter int MAX_CREDIT = 56,
  parameter int FCT_CHARS  = 8
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       enable_tx,
  input  logic       send_null_tx,
  input  logic       send_fct_tx,
  input  logic       link_run,
  input  logic       rx_got_fct,
  input  logic       rx_got_nchar,
  input  logic [6:0] rx_fifo_free,
  input  logic       tc_req,
  input  logic [7:0] tc_data,
  output logic       tc_ack,
  input  logic       data_valid,
  input  logic [8:0] data_in,
  output logic       data_ready,
  output logic       enc_valid,
  output logic [1:0] enc_type,
  output logic [8:0] enc_data,
  input  logic       enc_ready,
  output logic [5:0] tx_credit,
  output logic [5:0] rx_outstanding,
  output logic       credit_error
);
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;
  localparam logic [1:0] T_NULL = 2'b00, T_FCT = 2'b01, T_NCHAR = 2'b10, T_TC = 2'b11;
  localparam logic [6:0] MAX_C = 7'(MAX_CREDIT);
  localparam logic [6:0] FCT_C = 7'(FCT_CHARS);
  slot_t state_q, state_d;
  logic [1:0] type_q, type_d;
  logic [8:0] data_q, data_d;
  logic [6:0] tx_q, tx_d, rx_q, rx_d, tx_sum, rx_sum, rx_need;
  logic accept, tc_acc, fct_acc, nchar_acc, tx_ovf;
  logic tc_ok, fct_ok, nchar_ok, load, tc_ack_d, data_ready_d, credit_error_d;
  // Slot registers, counters and one-cycle acknowledge pulses
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= SLOT_EMPTY;
      type_q       <= T_NULL;
      data_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      tc_ack       <= 1'b0;
      data_ready   <= 1'b0;
      credit_error <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      data_q       <= data_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      tc_ack       <= tc_ack_d;
      data_ready   <= data_ready_d;
      credit_error <= credit_error_d;
    end
  end
  // Candidate selection, slot next-state and credit arithmetic; a source just accepted (or still
  // being acked) is masked so its stale request cannot be issued twice
  always_comb begin
    accept         = (state_q == SLOT_FULL) & enc_ready;
    tc_acc         = accept & (type_q == T_TC);
    fct_acc        = accept & (type_q == T_FCT);
    nchar_acc      = accept & (type_q == T_NCHAR);
    tx_ovf         = rx_got_fct & ((tx_q + FCT_C) > MAX_C);
    tx_sum         = tx_q + ((rx_got_fct & ~tx_ovf) ? FCT_C : 7'd0);
    tx_d           = (nchar_acc & (tx_sum != 7'd0)) ? tx_sum - 7'd1 : tx_sum;
    rx_sum         = rx_q + (fct_acc ? FCT_C : 7'd0);
    rx_d           = (rx_got_nchar & (rx_sum != 7'd0)) ? rx_sum - 7'd1 : rx_sum;
    rx_need        = rx_q + FCT_C;
    tc_ok          = tc_req & link_run & ~tc_acc & ~tc_ack;
    fct_ok         = send_fct_tx & ~fct_acc & (rx_need <= MAX_C) & (rx_fifo_free >= rx_need);
    nchar_ok       = data_valid & link_run & (tx_d != 7'd0) & ~nchar_acc & ~data_ready;
    load           = (state_q == SLOT_EMPTY) | accept;
    state_d        = load ? ((tc_ok | fct_ok | nchar_ok | send_null_tx) ? SLOT_FULL : SLOT_EMPTY) : state_q;
    type_d         = load ? (tc_ok ? T_TC : fct_ok ? T_FCT : nchar_ok ? T_NCHAR : T_NULL) : type_q;
    data_d         = load ? (tc_ok ? {1'b0, tc_data} : (nchar_ok & ~fct_ok) ? data_in : 9'd0) : data_q;
    tc_ack_d       = tc_acc;
    data_ready_d   = nchar_acc;
    credit_error_d = tx_ovf;
    if (!enable_tx) begin
      state_d        = SLOT_EMPTY;
      type_d         = T_NULL;
      data_d         = '0;
      tx_d           = '0;
      rx_d           = '0;
      tc_ack_d       = 1'b0;
      data_ready_d   = 1'b0;
      credit_error_d = 1'b0;
    end
  end
  assign enc_valid      = (state_q == SLOT_FULL);
  assign enc_type       = type_q;
  assign enc_data       = data_q;
  assign tx_credit      = (tx_q > MAX_C) ? 6'(MAX_CREDIT) : tx_q[5:0];
  assign rx_outstanding = (rx_q > MAX_C) ? 6'(MAX_CREDIT) : rx_q[5:0];
endmodule
